// File: rtl/mult4_pkg.sv
// ---------------------------------------------------------------------------
// mult4_pkg
// Shared definitions for the x(2**SHIFT) byte-stream scaler and its
// divide-by-4 companion. Both blocks size their data paths from the same
// defaults, so they stay in step when one of them changes.
//   state_t          : burst FSM state (IDLE between bursts, RUN inside one)
//   DEF_WIDTH        : default byte width
//   DEF_SHIFT        : default scale exponent (factor = 2**DEF_SHIFT)
//   DEF_COUNT_W      : default width of the burst length counter
// ---------------------------------------------------------------------------
package mult4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SHIFT   = 2;
  localparam int DEF_COUNT_W = 8;

endpackage

// File: rtl/multiplied4_stream_carry_shift_slice.sv
// ---------------------------------------------------------------------------
// carry_shift_slice
// Combinational left shift of one byte by SHIFT bits. The bits pushed out of
// the top become the carry for the next (more significant) byte, and the
// carry from the previous byte fills the vacated low bits.
// Ports:
//   byte_in    in   WIDTH   byte to scale
//   carry_in   in   SHIFT   bits carried out of the previous byte
//   byte_out   out  WIDTH   {byte_in[WIDTH-SHIFT-1:0], carry_in}
//   carry_out  out  SHIFT   byte_in[WIDTH-1:WIDTH-SHIFT]
// ---------------------------------------------------------------------------
module carry_shift_slice
  import mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic [WIDTH-1:0] byte_in,
  input  logic [SHIFT-1:0] carry_in,
  output logic [WIDTH-1:0] byte_out,
  output logic [SHIFT-1:0] carry_out
);

  assign byte_out  = {byte_in[WIDTH-SHIFT-1:0], carry_in};
  assign carry_out = byte_in[WIDTH-1:WIDTH-SHIFT];

endmodule

// File: rtl/multiplied4_stream.sv
// ---------------------------------------------------------------------------
// multiplied4_stream
// Scales a multi-byte unsigned number, delivered LSB byte first as a
// data_valid burst, by 2**SHIFT. Every input byte is re-emitted one cycle
// later with the carry from the previous byte shifted in; after the burst
// ends one extra byte carrying the final carry is appended and flagged last.
// Ports:
//   CLKin           in   1        clock, rising edge
//   reset           in   1        synchronous, active-high
//   data_in         in   WIDTH    input byte, sampled when data_valid=1
//   data_valid      in   1        burst qualifier (burst = maximal run of 1s)
//   data_out        out  WIDTH    scaled byte (0 when not valid)
//   data_valid_out  out  1        data_out qualifier
//   data_last_out   out  1        appended carry byte marker
//   ovf_out         out  1        with data_last_out: carry byte nonzero
//   len_out         out  COUNT_W  with data_last_out: input byte count (saturating)
// ---------------------------------------------------------------------------
module multiplied4_stream
  import mult4_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               CLKin,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               data_valid,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid_out,
  output logic               data_last_out,
  output logic               ovf_out,
  output logic [COUNT_W-1:0] len_out
);

  state_t             state_q, state_d;
  logic [SHIFT-1:0]   carry_q, carry_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] len_q, len_d;

  logic [SHIFT-1:0]   slice_carry_in;
  logic [WIDTH-1:0]   slice_byte_out;
  logic [SHIFT-1:0]   slice_carry_out;
  logic [COUNT_W-1:0] cnt_inc;

  // The first byte of a burst must not see a stale carry: feed zero in IDLE.
  assign slice_carry_in = (state_q == RUN) ? carry_q : '0;

  carry_shift_slice #(
    .WIDTH (WIDTH),
    .SHIFT (SHIFT)
  ) u_slice (
    .byte_in   (data_in),
    .carry_in  (slice_carry_in),
    .byte_out  (slice_byte_out),
    .carry_out (slice_carry_out)
  );

  // Saturating increment: the counter sticks at all-ones for long bursts.
  assign cnt_inc = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);

  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    ovf_d      = 1'b0;
    len_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d    = RUN;
          data_out_d = slice_byte_out;
          valid_d    = 1'b1;
          carry_d    = slice_carry_out;
          cnt_d      = COUNT_W'(1);
        end
      end
      RUN: begin
        if (data_valid) begin
          data_out_d = slice_byte_out;
          valid_d    = 1'b1;
          carry_d    = slice_carry_out;
          cnt_d      = cnt_inc;
        end else begin
          // Flush: the first idle cycle carries the final carry byte, so a
          // new burst can begin on the next cycle without any overlap.
          data_out_d = {{(WIDTH-SHIFT){1'b0}}, carry_q};
          valid_d    = 1'b1;
          last_d     = 1'b1;
          ovf_d      = (carry_q != '0);
          len_d      = cnt_q;
          carry_d    = '0;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKin) begin
    if (reset) begin
      state_q    <= IDLE;
      carry_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      len_q      <= len_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid_out = valid_q;
  assign data_last_out  = last_q;
  assign ovf_out        = ovf_q;
  assign len_out        = len_q;

endmodule

// File: tb/tb_multiplied4_stream.sv
// ---------------------------------------------------------------------------
// tb_multiplied4_stream
// Directed bench for multiplied4_stream with a scoreboard: expected output
// bytes are queued when a burst is driven and compared as the DUT emits them.
// Idle cycles are checked for all-zero outputs.
// ---------------------------------------------------------------------------
module tb_multiplied4_stream;

  localparam int WIDTH   = 8;
  localparam int SHIFT   = 2;
  localparam int COUNT_W = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       ovf;
    logic [7:0] len;
  } exp_t;

  logic               CLKin = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   data_in;
  logic               data_valid;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid_out;
  logic               data_last_out;
  logic               ovf_out;
  logic [COUNT_W-1:0] len_out;

  int   n_checks = 0;
  int   n_errs   = 0;
  bit   mon_en   = 1'b0;
  exp_t sb[$];
  byte unsigned burst[$];

  multiplied4_stream #(
    .WIDTH   (WIDTH),
    .SHIFT   (SHIFT),
    .COUNT_W (COUNT_W)
  ) dut (
    .CLKin          (CLKin),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_last_out  (data_last_out),
    .ovf_out        (ovf_out),
    .len_out        (len_out)
  );

  always #5 CLKin = ~CLKin;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [7:0] d, input logic last, input logic ovf,
                          input logic [7:0] len);
    exp_t e;
    e.d = d; e.last = last; e.ovf = ovf; e.len = len;
    sb.push_back(e);
  endtask

  // Golden model: long multiplication of the LSB-first byte number by 2**SHIFT.
  task automatic model_push();
    int carry = 0;
    int p;
    foreach (burst[i]) begin
      p     = int'(burst[i]) * (1 << SHIFT) + carry;
      exp_push(8'(p & 255), 1'b0, 1'b0, 8'd0);
      carry = p >> 8;
    end
    exp_push(8'(carry), 1'b1, carry != 0, (burst.size() > 255) ? 8'd255 : 8'(burst.size()));
  endtask

  // Drives the burst, then one idle cycle (which carries the flush).
  task automatic drive_burst();
    foreach (burst[i]) begin
      @(posedge CLKin); #1;
      data_valid = 1'b1;
      data_in    = burst[i];
    end
    @(posedge CLKin); #1;
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge CLKin) begin
    if (mon_en) begin
      if (data_valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 16'(data_valid_out), 16'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data_out", 16'(data_out), 16'(e.d));
          check("last",     16'(data_last_out), 16'(e.last));
          check("ovf",      16'(ovf_out), 16'(e.ovf));
          check("len",      16'(len_out), 16'(e.len));
          $display("out %02h last=%0d ovf=%0d len=%0d", data_out, data_last_out, ovf_out, len_out);
        end
      end else begin
        check("idle_zero", {data_out, 5'd0, data_last_out, ovf_out, 1'b0},
              16'd0);
        check("idle_len", 16'(len_out), 16'd0);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge CLKin);
    #1;
    reset = 1'b0;
    @(negedge CLKin);
    check("rst_data",  16'(data_out), 16'd0);
    check("rst_valid", 16'(data_valid_out), 16'd0);
    check("rst_last",  16'(data_last_out), 16'd0);
    check("rst_ovf",   16'(ovf_out), 16'd0);
    check("rst_len",   16'(len_out), 16'd0);
    mon_en = 1'b1;

    // 1: 0x7575 * 4 = 0x1D5D4
    exp_push(8'hD4, 0, 0, 0); exp_push(8'hD5, 0, 0, 0); exp_push(8'h01, 1, 1, 2);
    burst = '{8'h75, 8'h75}; drive_burst();
    // 2: 0x7581 * 4 = 0x1D604
    exp_push(8'h04, 0, 0, 0); exp_push(8'hD6, 0, 0, 0); exp_push(8'h01, 1, 1, 2);
    burst = '{8'h81, 8'h75}; drive_burst();
    // 3: 0x3541 * 4 = 0xD504
    exp_push(8'h04, 0, 0, 0); exp_push(8'hD5, 0, 0, 0); exp_push(8'h00, 1, 0, 2);
    burst = '{8'h41, 8'h35}; drive_burst();
    // 4: single 0xFF then 0x01 after exactly one idle cycle
    exp_push(8'hFC, 0, 0, 0); exp_push(8'h03, 1, 1, 1);
    burst = '{8'hFF}; drive_burst();
    exp_push(8'h04, 0, 0, 0); exp_push(8'h00, 1, 0, 1);
    burst = '{8'h01}; drive_burst();

    // 5: reset after the first byte of 0x75,0x75,0x75 discards the burst
    repeat (2) @(posedge CLKin);
    #1;
    exp_push(8'hD4, 0, 0, 0);
    data_valid = 1'b1; data_in = 8'h75;
    @(posedge CLKin); #1;
    reset = 1'b1; data_in = 8'h75;
    @(posedge CLKin); #1;
    reset = 1'b0; data_valid = 1'b0; data_in = '0;
    @(negedge CLKin);
    check("post_rst_valid", 16'(data_valid_out), 16'd0);
    check("post_rst_sb",    16'(sb.size()), 16'd0);
    exp_push(8'h04, 0, 0, 0); exp_push(8'h01, 1, 1, 1);
    burst = '{8'h41}; drive_burst();

    // 6: 300-byte burst of 0x40, length saturates at 255
    burst.delete();
    for (int i = 0; i < 300; i++) burst.push_back(8'h40);
    model_push(); drive_burst();

    // A few random bursts against the model
    for (int k = 0; k < 4; k++) begin
      burst.delete();
      for (int i = 0; i < int'($urandom_range(1, 9)); i++)
        burst.push_back(8'($urandom_range(0, 255)));
      model_push(); drive_burst();
    end

    // Drain with a bounded wait.
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge CLKin);
    repeat (3) @(posedge CLKin);
    @(negedge CLKin);
    check("sb_drained", 16'(sb.size()), 16'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
